uart_tx_fifo: RTL



---
 rtl/uart_tx_fifo.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART transmitter with FIFO, parity and stop-bit options
//
// Purpose: accepts words through a valid/full handshake into a small circular
// FIFO and serialises them LSB-first onto an idle-high line. Frames are sent
// back-to-back while the FIFO holds data.
//
// Ports:
//   tx_clk      clock
//   reset       synchronous active-high reset
//   data_in     word to transmit (DATA_W bits)
//   wr_en       push request, accepted when fifo_full=0
//   fifo_full   FIFO holds FIFO_DEPTH words
//   tx_ready    inverse of fifo_full
//   fifo_count  words queued, excluding the frame in flight
//   data_out    registered serial line, idle high
//   tx_busy     high from start bit through last stop bit
//   overflow    sticky flag, set by a push while full

module uart_tx_fifo #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          tx_clk,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          wr_en,
    output logic                          fifo_full,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          data_out,
    output logic                          tx_busy,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // FIFO storage; pointers carry an extra wrap bit to tell full from empty
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_ready   = ~fifo_full;
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Full is judged on the pre-edge pointers, so a pop in the same cycle
    // does not rescue a push into a full FIFO.
    assign push = wr_en & ~fifo_full;

    always_ff @(posedge tx_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_in;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
            if (wr_en && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Serialiser
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [CW-1:0]     baud_q;
    logic [BW-1:0]     bit_q;
    logic              stop_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic              baud_last;
    logic              stop_last;

    assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));
    // stop_q counts completed stop bits; with one stop bit every stop is the last.
    assign stop_last = (STOP_BITS == 1) || stop_q;

    // Pop from IDLE whenever data waits, or on the final stop cycle so the
    // next start bit follows with no idle gap.
    assign pop = ~fifo_empty &&
                 ((state_q == S_IDLE) ||
                  ((state_q == S_STOP) && baud_last && stop_last));

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            data_out <= 1'b1;
            tx_busy  <= 1'b0;
        end else if (pop) begin
            // Shared frame-load path for IDLE and end-of-stop.
            shift_q  <= head;
            parity_q <= (^head) ^ (PARITY_ODD != 0);
            baud_q   <= '0;
            state_q  <= S_START;
            data_out <= 1'b0;
            tx_busy  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q   <= '0;
                    data_out <= 1'b1;
                    tx_busy  <= 1'b0;
                end

                S_START: begin
                    if (baud_last) begin
                        baud_q   <= '0;
                        bit_q    <= '0;
                        state_q  <= S_DATA;
                        data_out <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == BW'(DATA_W - 1)) begin
                            if (PARITY_EN != 0) begin
                                state_q  <= S_PARITY;
                                data_out <= parity_q;
                            end else begin
                                state_q  <= S_STOP;
                                stop_q   <= 1'b0;
                                data_out <= 1'b1;
                            end
                        end else begin
                            // Shift right so the next bit is always at [1].
                            bit_q    <= bit_q + BW'(1);
                            shift_q  <= shift_q >> 1;
                            data_out <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (baud_last) begin
                        baud_q   <= '0;
                        state_q  <= S_STOP;
                        stop_q   <= 1'b0;
                        data_out <= 1'b1;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (stop_last) begin
                            // FIFO empty here, otherwise pop would have fired.
                            state_q  <= S_IDLE;
                            data_out <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end

                default: begin
                    state_q  <= S_IDLE;
                    data_out <= 1'b1;
                    tx_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
